// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss handler: stalls the pipeline, writes back a dirty victim, refills the
// missing block over the AXI block interface, and counts misses and writebacks.
module dcache_miss_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned BLOCK_WIDTH = 512,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_mem_access,
  input  logic                   i_dcache_hit,
  input  logic                   i_dcache_dirty,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic                   i_axi_wr_ack,
  input  logic                   i_axi_wr_done,
  input  logic                   i_axi_rd_ack,
  input  logic                   i_axi_rd_done,
  input  logic [BLOCK_WIDTH-1:0] i_axi_rd_block,
  output logic                   o_stall_mem,
  output logic                   o_axi_wr_req,
  output logic                   o_axi_rd_req,
  output logic [ADDR_WIDTH-1:0]  o_axi_addr,
  output logic                   o_block_we,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic [CNT_WIDTH-1:0]   o_miss_cnt,
  output logic [CNT_WIDTH-1:0]   o_wb_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_REQ,
    S_WB_WAIT,
    S_RD_REQ,
    S_RD_WAIT,
    S_FILL
  } state_t;

  // Clears the byte-offset bits so the refill address is block-aligned.
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [ADDR_WIDTH-1:0]  r_rd_addr;
  logic [ADDR_WIDTH-1:0]  r_wb_addr;
  logic [BLOCK_WIDTH-1:0] r_data_block;
  logic [CNT_WIDTH-1:0]   r_miss_cnt;
  logic [CNT_WIDTH-1:0]   r_wb_cnt;

  logic                   w_miss;
  logic                   w_take_miss;
  logic                   w_take_wb;
  logic                   w_capture;
  logic                   w_wr_req;
  logic                   w_rd_req;
  logic                   w_block_we;
  logic [ADDR_WIDTH-1:0]  w_axi_addr;

  assign w_miss = i_mem_access & ~i_dcache_hit;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx  = r_state;
    w_take_miss = 1'b0;
    w_take_wb   = 1'b0;
    w_capture   = 1'b0;
    w_wr_req    = 1'b0;
    w_rd_req    = 1'b0;
    w_block_we  = 1'b0;
    w_axi_addr  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_take_miss = 1'b1;
          if (i_dcache_dirty) begin
            w_take_wb  = 1'b1;
            w_state_nx = S_WB_REQ;
          end else begin
            w_state_nx = S_RD_REQ;
          end
        end
      end
      S_WB_REQ: begin
        w_wr_req   = 1'b1;
        w_axi_addr = r_wb_addr;
        if (i_axi_wr_ack) w_state_nx = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        if (i_axi_wr_done) w_state_nx = S_RD_REQ;
      end
      S_RD_REQ: begin
        w_rd_req   = 1'b1;
        w_axi_addr = r_rd_addr;
        if (i_axi_rd_ack) w_state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_axi_rd_done) begin
          w_capture  = 1'b1;
          w_state_nx = S_FILL;
        end
      end
      S_FILL: begin
        w_block_we = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_rd_addr    <= '0;
      r_wb_addr    <= '0;
      r_data_block <= '0;
      r_miss_cnt   <= '0;
      r_wb_cnt     <= '0;
    end else begin
      if (w_take_miss) begin
        r_rd_addr  <= i_addr & OFS_MASK;
        r_wb_addr  <= i_addr_wb;
        r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
      end
      if (w_take_wb) r_wb_cnt <= r_wb_cnt + CNT_WIDTH'(1);
      if (w_capture) r_data_block <= i_axi_rd_block;
    end
  end

  // Stall is raised combinationally in the miss cycle itself so the access never slips past.
  assign o_stall_mem  = (r_state == S_IDLE) ? w_miss : 1'b1;
  assign o_axi_wr_req = w_wr_req;
  assign o_axi_rd_req = w_rd_req;
  assign o_axi_addr   = w_axi_addr;
  assign o_block_we   = w_block_we;
  assign o_data_block = r_data_block;
  assign o_miss_cnt   = r_miss_cnt;
  assign o_wb_cnt     = r_wb_cnt;

endmodule
